debug_scan_ctrl: RTL and testbench

- Sits directly upstream of the mips core's debug port and drives `debug_addr` and `debug_step`.
- On request, sweeps `debug_addr` over a configured range and samples `debug_data` after the read latency.
- Presents each captured (address, word) pair on a valid/ready stream toward the display/UART front end.
- Converts a pre-debounced step request level into a single-cycle `debug_step` pulse.

---
 rtl/debug_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_debug_scan_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/debug_scan_ctrl.sv
// rtl/debug_scan_ctrl.sv - debug-port address sweeper with captured-word stream and step pulse
module debug_scan_ctrl #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 1,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 127
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_start,
    input  logic              step_req,
    output logic [ADDR_W-1:0] debug_addr,
    output logic              debug_step,
    input  logic [DATA_W-1:0] debug_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int CNT_W = $clog2(READ_LAT + 1);
    localparam logic [ADDR_W-1:0] FIRST  = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(LAST_ADDR);
    localparam logic [CNT_W-1:0]  LAT_M1 = CNT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             step_q;
    logic             start, capture, advance, finish;

    always_comb begin
        state_next = state;
        start      = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (scan_start) begin
                    start      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == LAT_M1) begin
                    capture    = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance    = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            debug_addr <= FIRST;
            debug_step <= 1'b0;
            out_valid  <= 1'b0;
            out_addr   <= FIRST;
            out_data   <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            step_q     <= 1'b0;
        end else begin
            state  <= state_next;
            step_q <= step_req;
            // Edges seen while a sweep runs are dropped; step_q still tracks the button.
            debug_step <= step_req & ~step_q & ~busy;

            if (start) begin
                debug_addr <= FIRST;
                cnt        <= '0;
                busy       <= 1'b1;
            end

            if (state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (capture) begin
                out_data  <= debug_data;
                out_addr  <= debug_addr;
                out_last  <= (debug_addr == LAST);
                out_valid <= 1'b1;
            end

            if (advance) begin
                out_valid  <= 1'b0;
                debug_addr <= debug_addr + ADDR_W'(1);
                cnt        <= '0;
            end

            if (finish) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_scan_ctrl.sv
// tb/tb_debug_scan_ctrl.sv - directed bench for debug_scan_ctrl (full range and single-word range)
module tb_debug_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_start, step_req, out_ready;
    logic [6:0]  debug_addr, out_addr;
    logic        debug_step, out_valid, out_last, busy;
    logic [31:0] debug_data, out_data;

    logic        s_start, s_step_req, s_ready;
    logic [6:0]  s_debug_addr, s_out_addr;
    logic        s_debug_step, s_out_valid, s_out_last, s_busy;
    logic [31:0] s_debug_data, s_out_data;

    int checks = 0;
    int failures = 0;
    int step_pulses = 0;

    always #5 clk = ~clk;

    // Core model: combinational read for READ_LAT=1, one register stage for READ_LAT=2.
    assign debug_data = {25'h0, debug_addr} + 32'h1000;
    always_ff @(posedge clk) s_debug_data <= {25'h0, s_debug_addr} + 32'h2000;

    always @(negedge clk) if (debug_step) step_pulses++;

    debug_scan_ctrl dut (
        .clk(clk), .rst(rst), .scan_start(scan_start), .step_req(step_req),
        .debug_addr(debug_addr), .debug_step(debug_step), .debug_data(debug_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    debug_scan_ctrl #(.READ_LAT(2), .FIRST_ADDR(3), .LAST_ADDR(3)) dut_single (
        .clk(clk), .rst(rst), .scan_start(s_start), .step_req(s_step_req),
        .debug_addr(s_debug_addr), .debug_step(s_debug_step), .debug_data(s_debug_data),
        .out_valid(s_out_valid), .out_ready(s_ready), .out_addr(s_out_addr),
        .out_data(s_out_data), .out_last(s_out_last), .busy(s_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // mode 0: out_ready high; mode 1: out_ready pattern 0,0,1.
    task automatic run_sweep(input int mode, input int start_at, input int rst_at,
                             input int step_at, input bit step_with_start);
        int          exp_a = 0;
        int          last_k = -1;
        int          first_k = -1;
        bit          pv = 0, phs = 0, pulsed = 0, rdy, hs;
        logic [40:0] pw = '0;
        logic [31:0] exp_d;
        @(negedge clk);
        scan_start = 1'b1;
        if (step_with_start) step_req = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        for (int k = 1; k < 1500; k++) begin
            if (last_k >= 0 && k == last_k + 1) begin
                check("busy_fall", {busy, out_valid}, 2'b00);
                break;
            end
            if (rst_at >= 0 && exp_a == rst_at && out_valid) begin
                out_ready = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("mid_rst", {out_valid, busy, debug_addr}, 9'd0);
                check("mid_rst_words", exp_a, rst_at);
                return;
            end
            if (pv && !phs)
                check("hold", {out_valid, out_addr, out_data, out_last}, pw);
            rdy = (mode == 0) ? 1'b1 : (k % 3 == 2);
            out_ready = rdy;
            scan_start = 1'b0;
            if (exp_a == start_at && out_valid && !pulsed) begin
                scan_start = 1'b1;
                pulsed = 1'b1;
            end
            if (step_at >= 0 && exp_a == step_at) step_req = 1'b1;
            if (out_valid && first_k < 0) first_k = k;
            hs = out_valid && rdy;
            if (hs) begin
                exp_d = 32'h1000 + exp_a;
                check("word", {busy, out_addr, out_data, out_last},
                      {1'b1, 7'(exp_a), exp_d, exp_a == 127});
                if (exp_a == 127) last_k = k;
                exp_a++;
            end
            pv = out_valid;
            phs = hs;
            pw = {out_valid, out_addr, out_data, out_last};
            @(negedge clk);
        end
        scan_start = 1'b0;
        check("word_count", exp_a, 128);
        if (mode == 0) begin
            check("first_valid", first_k, 2);
            check("last_hs_cycle", last_k, 256);
        end
    endtask

    initial begin
        int p0, first, n;
        rst = 1'b1; scan_start = 0; step_req = 0; out_ready = 0;
        s_start = 0; s_step_req = 0; s_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_idle", {debug_addr, out_valid, busy, debug_step}, 10'd0);
        end
        check("reset_out", {out_addr, out_data, out_last}, 40'd0);

        run_sweep(0, -1, -1, -1, 1'b0);
        run_sweep(1, -1, -1, -1, 1'b0);
        run_sweep(0, 5, 40, -1, 1'b0);
        run_sweep(0, -1, -1, -1, 1'b0);

        p0 = step_pulses;
        step_req = 1'b1;
        repeat (20) @(negedge clk);
        step_req = 1'b0;
        repeat (3) @(negedge clk);
        check("step_once", step_pulses - p0, 1);

        p0 = step_pulses;
        run_sweep(0, -1, -1, 10, 1'b0);
        repeat (5) @(negedge clk);
        step_req = 1'b0;
        repeat (5) @(negedge clk);
        check("step_in_sweep", step_pulses - p0, 0);

        p0 = step_pulses;
        run_sweep(0, -1, -1, -1, 1'b1);
        repeat (3) @(negedge clk);
        step_req = 1'b0;
        repeat (3) @(negedge clk);
        check("step_with_start", step_pulses - p0, 1);

        @(negedge clk);
        s_start = 1'b1;
        s_ready = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        first = -1;
        n = 0;
        for (int k = 1; k < 12; k++) begin
            if (s_out_valid) begin
                n++;
                if (first < 0) begin
                    first = k;
                    check("single_word", {s_out_addr, s_out_data, s_out_last},
                          {7'd3, 32'h2003, 1'b1});
                end
            end
            @(negedge clk);
        end
        check("single_latency", first, 3);
        check("single_count", n, 1);
        check("single_idle", {s_busy, s_out_valid, s_debug_addr}, {2'b00, 7'd3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
